count_sequence_checker: RTL and testbench

//   Receive-side monitor for the free-running up-counter output bus. It samples the

---
 rtl/count_sequence_checker.sv | 120 ++++++++++++
 tb/tb_count_sequence_checker.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/count_sequence_checker.sv
// count_sequence_checker: locks onto a +1-per-cycle count bus and flags breaks.
// Ports: clk, reset (async, active-low), check_en, count_in -> locked, error, wrap, err_count, expected.
module count_sequence_checker #(
    parameter int WIDTH    = 4,
    parameter int LOCK_LEN = 2,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             check_en,
    input  logic [WIDTH-1:0] count_in,
    output logic             locked,
    output logic             error,
    output logic             wrap,
    output logic [ERR_W-1:0] err_count,
    output logic [WIDTH-1:0] expected
);

    localparam int MW = $clog2(LOCK_LEN + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t           state;
    state_t           state_d;
    logic [MW-1:0]    match_cnt;
    logic [MW-1:0]    match_d;
    logic [WIDTH-1:0] exp_d;
    logic             hit;
    logic             last;
    logic             sat;
    logic             locked_d;
    logic             error_d;
    logic             wrap_d;
    logic             err_inc;

    // expected always holds ref+1, so it doubles as the reference register
    assign hit  = (count_in == expected);
    assign last = (match_cnt == MW'(LOCK_LEN - 1));
    assign sat  = &err_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            match_cnt <= '0;
            expected  <= '0;
        end else begin
            state     <= state_d;
            match_cnt <= match_d;
            expected  <= exp_d;
        end
    end

    always_comb begin
        state_d = state;
        match_d = match_cnt;
        exp_d   = expected;
        if (!check_en) begin
            state_d = IDLE;
        end else begin
            // every active sample becomes the new reference
            exp_d = count_in + WIDTH'(1);
            unique case (state)
                IDLE: begin
                    state_d = SYNC;
                    match_d = '0;
                end
                SYNC: begin
                    if (hit && last) begin
                        state_d = LOCKED;
                        match_d = '0;
                    end else if (hit) begin
                        match_d = match_cnt + MW'(1);
                    end else begin
                        match_d = '0;
                    end
                end
                LOCKED: begin
                    if (!hit) begin
                        state_d = SYNC;
                        match_d = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    match_d = '0;
                end
            endcase
        end
    end

    always_comb begin
        locked_d = (state_d == LOCKED);
        // a drop of check_en masks any mismatch on the same edge
        error_d  = check_en && (state == LOCKED) && !hit;
        wrap_d   = check_en && (state == LOCKED) && hit
                   && (count_in == '0);
        err_inc  = error_d && !sat;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            locked    <= 1'b0;
            error     <= 1'b0;
            wrap      <= 1'b0;
            err_count <= '0;
        end else begin
            locked <= locked_d;
            error  <= error_d;
            wrap   <= wrap_d;
            if (err_inc) begin
                err_count <= err_count + ERR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_count_sequence_checker.sv
// tb_count_sequence_checker: random and directed stimulus against a behavioural model.
// Ports: drives clk, reset, check_en, count_in; checks all DUT outputs each cycle.
module tb_count_sequence_checker;

    localparam int W    = 4;
    localparam int LL   = 2;
    localparam int EW   = 8;
    localparam int MOD  = 1 << W;
    localparam int MAXC = (1 << EW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          check_en = 1'b0;
    logic [W-1:0]  count_in = '0;
    logic          locked;
    logic          error;
    logic          wrap;
    logic [EW-1:0] err_count;
    logic [W-1:0]  expected;

    int n_vec = 0;
    int n_bad = 0;

    // behavioural model
    bit m_active = 0;
    bit m_locked = 0;
    bit m_err    = 0;
    bit m_wrap   = 0;
    int m_streak = 0;
    int m_exp    = 0;
    int m_cnt    = 0;

    int cur = 0;

    count_sequence_checker #(
        .WIDTH(W),
        .LOCK_LEN(LL),
        .ERR_W(EW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .check_en(check_en),
        .count_in(count_in),
        .locked(locked),
        .error(error),
        .wrap(wrap),
        .err_count(err_count),
        .expected(expected)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int want);
        n_vec++;
        if (act != want) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, want, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 0;
        m_locked = 0;
        m_err    = 0;
        m_wrap   = 0;
        m_streak = 0;
        m_exp    = 0;
        m_cnt    = 0;
    endtask

    task automatic model_step(input bit en, input int c);
        bit good;
        m_err  = 0;
        m_wrap = 0;
        if (!en) begin
            m_active = 0;
            m_locked = 0;
        end else if (!m_active) begin
            m_active = 1;
            m_locked = 0;
            m_streak = 0;
            m_exp    = (c + 1) % MOD;
        end else begin
            good = (c == m_exp);
            if (m_locked) begin
                if (good) begin
                    m_wrap = (c == 0);
                end else begin
                    m_err    = 1;
                    m_locked = 0;
                    m_streak = 0;
                    if (m_cnt < MAXC) m_cnt++;
                end
            end else if (good) begin
                m_streak++;
                if (m_streak >= LL) begin
                    m_locked = 1;
                    m_streak = 0;
                end
            end else begin
                m_streak = 0;
            end
            m_exp = (c + 1) % MOD;
        end
    endtask

    task automatic step(input bit en, input int c);
        check_en = en;
        count_in = W'(c);
        cur      = c;
        @(posedge clk);
        model_step(en, c);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        chk("locked", int'(locked), int'(m_locked));
        chk("error", int'(error), int'(m_err));
        chk("wrap", int'(wrap), int'(m_wrap));
        chk("err_count", int'(err_count), m_cnt);
        chk("expected", int'(expected), m_exp);
    end

    initial begin
        int b;
        int r;
        bit en;
        int c;
        #12;
        chk("rst_locked", int'(locked), 0);
        chk("rst_cnt", int'(err_count), 0);
        #8;
        reset = 1'b1;

        step(1, 0);
        step(1, 1);
        chk("t1_nolock", int'(locked), 0);
        step(1, 2);
        chk("t1_lock", int'(locked), 1);
        for (int i = 3; i < 16; i++) step(1, i);
        step(1, 0);
        chk("t2_wrap", int'(wrap), 1);
        chk("t2_err", int'(error), 0);
        step(1, 1);
        chk("t2_wrap_end", int'(wrap), 0);

        for (int i = 2; i <= 6; i++) step(1, i);
        step(1, 9);
        chk("t3_err", int'(error), 1);
        chk("t3_cnt", int'(err_count), 1);
        chk("t3_unlock", int'(locked), 0);
        step(1, 10);
        chk("t3_unlock2", int'(locked), 0);
        chk("t3_err_end", int'(error), 0);
        step(1, 11);
        chk("t3_relock", int'(locked), 1);
        chk("t3_exp", int'(expected), 12);
        step(1, 12);

        step(1, 0);
        chk("t4_err", int'(error), 1);
        chk("t4_cnt", int'(err_count), 2);
        for (int i = 0; i < 4; i++) begin
            step(1, 0);
            chk("t4_quiet", int'(error), 0);
        end
        step(1, 1);
        chk("t4_sync", int'(locked), 0);
        step(1, 2);
        chk("t4_relock", int'(locked), 1);
        chk("t4_cnt2", int'(err_count), 2);

        step(0, 7);
        chk("t6_dis_lock", int'(locked), 0);
        chk("t6_dis_err", int'(error), 0);
        chk("t6_dis_cnt", int'(err_count), 2);
        chk("t6_dis_exp", int'(expected), 3);

        for (int i = 0; i < 600; i++) begin
            r  = $urandom_range(0, 19);
            en = (r != 0);
            if (r == 1) c = cur;
            else if (r == 2) c = $urandom_range(0, MOD - 1);
            else c = (cur + 1) % MOD;
            step(en, c);
        end

        for (int i = 0; i < 4; i++) step(1, (cur + 1) % MOD);
        for (int i = 0; i < 300; i++) begin
            b = (cur + 5) % MOD;
            step(1, b);
            step(1, (b + 1) % MOD);
            step(1, (b + 2) % MOD);
        end
        chk("t5_sat", int'(err_count), 255);
        step(1, (cur + 7) % MOD);
        chk("t5_hold", int'(err_count), 255);

        for (int i = 0; i < 4; i++) step(1, (cur + 1) % MOD);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_locked", int'(locked), 0);
        chk("t6_cnt", int'(err_count), 0);
        chk("t6_exp", int'(expected), 0);
        chk("t6_err", int'(error), 0);
        model_reset();
        #1;
        reset = 1'b1;
        step(1, 5);
        chk("t6_post", int'(locked), 0);
        step(1, 6);
        step(1, 7);
        chk("t6_relock", int'(locked), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
